// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU result types and saturation helper
package alu_pkg;
  localparam int ALU_WIDTH = 32;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;
  typedef struct packed {
    logic [ALU_WIDTH-1:0] result;
    flags_t flags;
  } result_entry_t;
  function automatic logic [ALU_WIDTH-1:0] sat_result(input logic [ALU_WIDTH-1:0] sum, input logic ovf);
    return ovf ? (sum[ALU_WIDTH-1] ? {1'b0, {(ALU_WIDTH-1){1'b1}}} : {1'b1, {(ALU_WIDTH-1){1'b0}}}) : sum;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: valid/ready FIFO with registered head and separate occupancy counter
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] occ;
  logic push, pop;
  assign in_ready  = (occ != (AW+1)'(DEPTH)) & rst_n;
  assign out_valid = (occ != '0) & rst_n;
  assign out_data  = rst_n ? mem[rd] : '0;
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr  <= '0;
      rd  <= '0;
      occ <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
    end
  // storage is not reset; occupancy alone decides what is valid
  always_ff @(posedge clk)
    if (push) mem[wr] <= in_data;
endmodule

// File: rtl/adder_result_stage.sv
// adder_result_stage: registers adder results with NZCV flags, optional saturation and overflow counting
module adder_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 2,
  parameter int SATURATE = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Sum,
  input  logic             Cout,
  input  logic             Overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             FlagN,
  output logic             FlagZ,
  output logic             FlagC,
  output logic             FlagV,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] OvfCount
);
  logic [WIDTH-1:0] res;
  flags_t fin, fout;
  // clamp toward the sign the true result would have had; C and V stay raw
  always_comb begin
    res = (SATURATE != 0 && Overflow) ? (Sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}}) : Sum;
    fin = '{n: res[WIDTH-1], z: res == '0, c: Cout, v: Overflow};
  end
  sync_fifo #(.DEPTH(DEPTH), .W(WIDTH+4)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data({res, fin}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data({Result, fout})
  );
  assign FlagN = fout.n;
  assign FlagZ = fout.z;
  assign FlagC = fout.c;
  assign FlagV = fout.v;
  // sticky overflow event count; clear beats a same-cycle increment
  always_ff @(posedge clk)
    if (!rst_n || clr_cnt) OvfCount <= '0;
    else if (in_valid && in_ready && Overflow && !(&OvfCount)) OvfCount <= OvfCount + 1'b1;
endmodule

// File: tb/tb_adder_result_stage.sv
// tb_adder_result_stage: randomized scoreboard bench for a pass-through and a saturating instance
module tb_adder_result_stage;
  logic clk = 0, rst_n = 0, in_valid = 0, cout = 0, ovf = 0, out_ready = 0, clr_cnt = 0;
  logic [31:0] sum = 0;
  logic ir0, ov0, n0, z0, c0, v0, ir1, ov1, n1, z1, c1, v1;
  logic [31:0] r0, r1;
  logic [15:0] cnt0;
  logic [1:0] cnt1;
  int tests = 0, fails = 0;
  logic [35:0] q0[$], q1[$];
  int m0 = 0, m1 = 0;

  adder_result_stage #(.WIDTH(32), .DEPTH(2), .SATURATE(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .Sum(sum), .Cout(cout),
    .Overflow(ovf), .out_valid(ov0), .out_ready(out_ready), .Result(r0), .FlagN(n0), .FlagZ(z0),
    .FlagC(c0), .FlagV(v0), .clr_cnt(clr_cnt), .OvfCount(cnt0));
  adder_result_stage #(.WIDTH(32), .DEPTH(2), .SATURATE(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .Sum(sum), .Cout(cout),
    .Overflow(ovf), .out_valid(ov1), .out_ready(out_ready), .Result(r1), .FlagN(n1), .FlagZ(z1),
    .FlagC(c1), .FlagV(v1), .clr_cnt(clr_cnt), .OvfCount(cnt1));

  always #5 clk = ~clk;

  function automatic logic [35:0] model(input logic [31:0] s, input logic c, input logic o, input bit sat);
    logic [31:0] r;
    r = (sat && o) ? (s[31] ? 32'h7fffffff : 32'h80000000) : s;
    return {r, r[31], r == 0, c, o};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // monitor/scoreboard: compare visible state, then advance the model to the next edge
  always @(negedge clk) begin
    bit push, pop;
    check("in_ready0", 64'(ir0), 64'(rst_n && q0.size() < 2));
    check("in_ready1", 64'(ir1), 64'(rst_n && q1.size() < 2));
    check("out_valid0", 64'(ov0), 64'(rst_n && q0.size() != 0));
    check("out_valid1", 64'(ov1), 64'(rst_n && q1.size() != 0));
    if (!rst_n) begin
      check("reset_head0", 64'({r0, n0, z0, c0, v0}), 64'(0));
      check("reset_head1", 64'({r1, n1, z1, c1, v1}), 64'(0));
    end else begin
      if (q0.size() != 0) check("head0", 64'({r0, n0, z0, c0, v0}), 64'(q0[0]));
      if (q1.size() != 0) check("head1", 64'({r1, n1, z1, c1, v1}), 64'(q1[0]));
    end
    check("ovfcnt0", 64'(cnt0), 64'(m0));
    check("ovfcnt1", 64'(cnt1), 64'(m1));
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      m0 = 0;
      m1 = 0;
    end else begin
      push = in_valid && q0.size() < 2;
      pop = q0.size() != 0 && out_ready;
      if (pop) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      if (push) begin
        q0.push_back(model(sum, cout, ovf, 0));
        q1.push_back(model(sum, cout, ovf, 1));
      end
      m0 = clr_cnt ? 0 : (push && ovf && m0 < 65535) ? m0 + 1 : m0;
      m1 = clr_cnt ? 0 : (push && ovf && m1 < 3) ? m1 + 1 : m1;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [31:0] s, input logic c, input logic o);
    in_valid = 1;
    sum = s;
    cout = c;
    ovf = o;
    cyc();
    in_valid = 0;
  endtask

  initial begin
    in_valid = 1;
    cyc(3);
    rst_n = 1;
    in_valid = 0;
    out_ready = 1;
    drive(32'h80000000, 0, 1);
    drive(32'h00000000, 1, 0);
    drive(32'h7fffffff, 1, 1);
    cyc(3);
    out_ready = 0;
    drive(32'h5, 0, 0);
    drive(32'h99999999, 0, 0);
    drive(32'h12345678, 1, 1);
    cyc(2);
    out_ready = 1;
    cyc(3);
    drive(32'h1000, 0, 0);
    for (int i = 0; i < 8; i++) drive(32'h2000 + i, i[0], 0);
    cyc(3);
    clr_cnt = 1;
    cyc();
    clr_cnt = 0;
    for (int i = 0; i < 4; i++) drive(32'h40000000 + i, 0, 1);
    cyc(2);
    clr_cnt = 1;
    drive(32'h80000001, 1, 1);
    clr_cnt = 0;
    cyc(3);
    for (int i = 0; i < 1500; i++) begin
      int k;
      k = $urandom_range(0, 3);
      in_valid = $urandom_range(0, 3) != 0;
      sum = k == 0 ? 32'h0 : k == 1 ? 32'h7fffffff : k == 2 ? 32'h80000000 : $urandom;
      cout = 1'($urandom);
      ovf = 1'($urandom);
      out_ready = $urandom_range(0, 7) < ((i / 250) % 4) * 2 + 1;
      clr_cnt = $urandom_range(0, 31) == 0;
      rst_n = $urandom_range(0, 199) != 0;
      cyc();
    end
    rst_n = 1;
    in_valid = 0;
    clr_cnt = 0;
    out_ready = 1;
    cyc(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
